// File: rtl/masking_pkg.sv
// Shared definitions for the first-order masking datapath: PRNG taps, default
// seed, share-generator state encoding, share bundle layout and the LFSR unroll.
package masking_pkg;

   localparam int unsigned MASK_LFSR_W = 32;
   localparam int unsigned TAP_A       = 31;
   localparam int unsigned TAP_B       = 21;
   localparam int unsigned TAP_C       = 1;
   localparam int unsigned TAP_D       = 0;
   localparam int unsigned ADV_STEPS   = 5;
   localparam int unsigned WCNT_W      = 8;
   localparam int unsigned MASK_W      = 5;

   localparam logic [MASK_LFSR_W-1:0] MASK_SEED = 32'hACE1_2468;

   typedef enum logic {
      ST_WARMUP = 1'b0,
      ST_RUN    = 1'b1
   } gen_state_e;

   typedef struct packed {
      logic a0;
      logic a1;
      logic b0;
      logic b1;
      logic c0;
      logic c1;
      logic rn0;
      logic rn1;
   } share_bundle_t;

   // Fibonacci x^32+x^22+x^2+x+1, five steps unrolled into one cycle.
   function automatic logic [MASK_LFSR_W-1:0] lfsr_adv5(input logic [MASK_LFSR_W-1:0] s);
      logic [MASK_LFSR_W-1:0] t;
      t = s;
      for (int unsigned i = 0; i < ADV_STEPS; i++) begin
         t = {t[MASK_LFSR_W-2:0], t[TAP_A] ^ t[TAP_B] ^ t[TAP_C] ^ t[TAP_D]};
      end
      return t;
   endfunction

endpackage

// File: rtl/masking_lfsr.sv
// Mask PRNG: 32-bit LFSR with reload and 5-step advance. An all-zero seed
// would lock the LFSR, so it is replaced by 1 both at reset and on reload.
module masking_lfsr
   import masking_pkg::*;
#(
   parameter logic [MASK_LFSR_W-1:0] SEED = MASK_SEED
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   load,
   input  logic [MASK_LFSR_W-1:0] load_val,
   input  logic                   adv,
   output logic [MASK_W-1:0]      mask
);

   localparam logic [MASK_LFSR_W-1:0] RST_VAL =
      (SEED == '0) ? MASK_LFSR_W'(1) : SEED;

   logic [MASK_LFSR_W-1:0] lfsr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= RST_VAL;
      end else if (load) begin
         lfsr_q <= (load_val == '0) ? MASK_LFSR_W'(1) : load_val;
      end else if (adv) begin
         lfsr_q <= lfsr_adv5(lfsr_q);
      end
   end

   // Mask bits come from the state before the advance.
   assign mask = lfsr_q[MASK_W-1:0];

endmodule

// File: rtl/masking_share_gen.sv
// Share generator: splits a/b/c into Boolean shares with fresh LFSR masks and
// emits the refresh bits for the downstream masked AND, behind valid/ready.
module masking_share_gen
   import masking_pkg::*;
#(
   parameter int unsigned       LFSR_W = MASK_LFSR_W,
   parameter logic [LFSR_W-1:0] SEED   = MASK_SEED,
   parameter int unsigned       WARMUP = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              seed_load,
   input  logic [LFSR_W-1:0] seed_in,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              a,
   input  logic              b,
   input  logic              c,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              a0,
   output logic              a1,
   output logic              b0,
   output logic              b1,
   output logic              c0,
   output logic              c1,
   output logic              rN0,
   output logic              rN1,
   output logic              busy
);

   localparam logic [WCNT_W-1:0] CNT_INIT = WCNT_W'(WARMUP - 1);

   gen_state_e        state_q, state_d;
   logic [WCNT_W-1:0] cnt_q, cnt_d;
   logic              busy_q;
   logic              out_valid_q;
   share_bundle_t     bundle_q, bundle_d;
   logic [MASK_W-1:0] mask;
   logic              accept;
   logic              adv;

   // in_ready never depends on in_valid; seed_load blocks acceptance.
   assign in_ready = (state_q == ST_RUN) && (!out_valid_q || out_ready) && !seed_load;
   assign accept   = in_valid && in_ready;
   assign adv      = accept || ((state_q == ST_WARMUP) && !seed_load);

   masking_lfsr #(
      .SEED (SEED)
   ) u_lfsr (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (seed_load),
      .load_val (seed_in),
      .adv      (adv),
      .mask     (mask)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_WARMUP;
         cnt_q   <= CNT_INIT;
         busy_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= (state_d == ST_WARMUP);
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (seed_load) begin
         state_d = ST_WARMUP;
         cnt_d   = CNT_INIT;
      end else begin
         case (state_q)
            ST_WARMUP: begin
               if (cnt_q == '0) begin
                  state_d = ST_RUN;
               end else begin
                  cnt_d = cnt_q - WCNT_W'(1);
               end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_WARMUP;
         endcase
      end
   end

   always_comb begin
      bundle_d     = '0;
      bundle_d.a0  = a ^ mask[0];
      bundle_d.a1  = mask[0];
      bundle_d.b0  = b ^ mask[1];
      bundle_d.b1  = mask[1];
      bundle_d.c0  = c ^ mask[2];
      bundle_d.c1  = mask[2];
      bundle_d.rn0 = mask[3];
      bundle_d.rn1 = mask[4];
   end

   // A reseed discards any held bundle so stale masks never leave the stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         bundle_q    <= '0;
      end else if (seed_load) begin
         out_valid_q <= 1'b0;
         bundle_q    <= '0;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         bundle_q    <= bundle_d;
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign a0        = bundle_q.a0;
   assign a1        = bundle_q.a1;
   assign b0        = bundle_q.b0;
   assign b1        = bundle_q.b1;
   assign c0        = bundle_q.c0;
   assign c1        = bundle_q.c1;
   assign rN0       = bundle_q.rn0;
   assign rN1       = bundle_q.rn1;

endmodule

// File: tb/tb_masking_share_gen.sv
// Bench for masking_share_gen: warm-up table, scoreboarded streaming against
// an independent bit-serial LFSR model, back-pressure, reseed and mid-run reset.
module tb_masking_share_gen;

   logic        clk;
   logic        rst_n;
   logic        seed_load;
   logic [31:0] seed_in;
   logic        in_valid;
   logic        in_ready;
   logic        a, b, c;
   logic        out_valid;
   logic        out_ready;
   logic        a0, a1, b0, b1, c0, c1, rN0, rN1;
   logic        busy;

   int          checks   = 0;
   int          failures = 0;
   int          npops    = 0;
   logic [31:0] ms;
   logic [7:0]  exp_q[$];

   typedef struct {
      logic in_valid;
      logic a;
      logic b;
      logic c;
      logic out_ready;
      logic exp_rdy;
      logic exp_busy;
      logic exp_ov;
   } vec_t;

   vec_t vt[10];

   masking_share_gen dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .seed_load (seed_load),
      .seed_in   (seed_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .c         (c),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .a0        (a0),
      .a1        (a1),
      .b0        (b0),
      .b1        (b1),
      .c0        (c0),
      .c1        (c1),
      .rN0       (rN0),
      .rN1       (rN1),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] m_step5(input logic [31:0] s);
      logic [31:0] t;
      logic        fb;
      t = s;
      for (int k = 0; k < 5; k++) begin
         fb = t[31] ^ t[21] ^ t[1] ^ t[0];
         t  = {t[30:0], fb};
      end
      return t;
   endfunction

   function automatic logic [7:0] dut_bundle();
      return {a0, a1, b0, b1, c0, c1, rN0, rN1};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic model_reset(input logic [31:0] seed);
      ms = (seed == 32'h0) ? 32'h1 : seed;
      repeat (8) ms = m_step5(ms);
      exp_q.delete();
   endtask

   // One cycle: inputs already driven at the negedge; sample, score, advance.
   task automatic tick();
      logic       acc, pop;
      logic [4:0] m;
      #1;
      acc = in_valid && in_ready;
      pop = out_valid && out_ready;
      if (pop) begin
         npops++;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL pop_unexpected actual=%h expected=none", dut_bundle());
         end else begin
            check("bundle", 32'(dut_bundle()), 32'(exp_q.pop_front()));
         end
      end
      if (acc) begin
         m = ms[4:0];
         exp_q.push_back({a ^ m[0], m[0], b ^ m[1], m[1], c ^ m[2], m[2], m[3], m[4]});
         ms = m_step5(ms);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic iv, input logic orr);
      in_valid  = iv;
      out_ready = orr;
      a = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      c = 1'($urandom_range(0, 1));
   endtask

   initial begin
      int pops0;
      rst_n = 1'b0; seed_load = 1'b0; seed_in = 32'h0;
      in_valid = 1'b0; out_ready = 1'b0; a = 1'b0; b = 1'b0; c = 1'b0;

      for (int i = 0; i < 10; i++) begin
         vt[i] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      end
      vt[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vt[9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

      @(negedge clk); @(negedge clk); #1;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd1);
      check("rst_bundle", 32'(dut_bundle()), 32'd0);
      check("rst_lfsr", dut.u_lfsr.lfsr_q, 32'hACE1_2468);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset(32'hACE1_2468);

      // Warm-up and first transaction from the table.
      for (int i = 0; i < 10; i++) begin
         in_valid = vt[i].in_valid; a = vt[i].a; b = vt[i].b; c = vt[i].c;
         out_ready = vt[i].out_ready;
         #1;
         check($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(vt[i].exp_rdy));
         check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(vt[i].exp_busy));
         check($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(vt[i].exp_ov));
         if (i == 9) begin
            check("recomb_a", 32'(a0 ^ a1), 32'd1);
            check("recomb_b", 32'(b0 ^ b1), 32'd1);
            check("recomb_c", 32'(c0 ^ c1), 32'd0);
         end
         tick();
      end

      // Full throughput.
      pops0 = npops;
      for (int i = 0; i < 64; i++) begin
         drive(1'b1, 1'b1);
         #1;
         check("stream_in_ready", 32'(in_ready), 32'd1);
         check("stream_out_valid", 32'(out_valid), 32'd1);
         tick();
      end
      check("stream_pops", 32'(npops - pops0), 32'd64);

      // Back-pressure: bundle and LFSR must hold.
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b0);
         #1;
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_bundle", 32'(dut_bundle()), 32'(exp_q[0]));
         check("bp_lfsr", dut.u_lfsr.lfsr_q, ms);
         tick();
      end
      pops0 = npops;
      drive(1'b1, 1'b1);
      #1;
      check("bp_release_in_ready", 32'(in_ready), 32'd1);
      tick();
      check("bp_release_pop", 32'(npops - pops0), 32'd1);
      check("bp_release_pending", 32'(exp_q.size()), 32'd1);

      // Reseed with zero while a bundle is pending and input offered.
      drive(1'b1, 1'b0);
      seed_load = 1'b1; seed_in = 32'h0;
      #1;
      check("seed_in_ready", 32'(in_ready), 32'd0);
      check("seed_pre_out_valid", 32'(out_valid), 32'd1);
      tick();
      seed_load = 1'b0;
      model_reset(32'h0);
      #1;
      check("seed_lfsr_one", dut.u_lfsr.lfsr_q, 32'h1);
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b1);
         #1;
         check("seed_busy", 32'(busy), 32'd1);
         check("seed_out_valid", 32'(out_valid), 32'd0);
         check("seed_in_ready", 32'(in_ready), 32'd0);
         tick();
      end
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 1'b1);
         #1;
         check("reseed_in_ready", 32'(in_ready), 32'd1);
         tick();
      end

      // Asynchronous reset mid-stream.
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b1);
         tick();
      end
      #2;
      rst_n = 1'b0;
      #1;
      check("mrst_out_valid", 32'(out_valid), 32'd0);
      check("mrst_in_ready", 32'(in_ready), 32'd0);
      check("mrst_busy", 32'(busy), 32'd1);
      check("mrst_bundle", 32'(dut_bundle()), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset(32'hACE1_2468);
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b1);
         #1;
         check("mrst_warm_in_ready", 32'(in_ready), 32'd0);
         tick();
      end
      for (int i = 0; i < 24; i++) begin
         drive(1'b1, 1'b1);
         tick();
      end
      drive(1'b0, 1'b1);
      tick();
      tick();
      check("drain_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/masking_share_gen.md
# masking_share_gen

Upstream share-generation stage for the first-order masked gate datapath. It accepts unmasked bits a, b, c over a valid/ready handshake and splits each into two Boolean shares using fresh LFSR randomness. It also produces the two refresh bits rN0/rN1 that the downstream three-input masked AND consumes. Outputs are registered: one transaction in, one share bundle out, with a one-cycle minimum latency.

## Interface
- LFSR_W, 32: PRNG state width; fixed at 32 for the taps below.
- SEED, 32'hACE1_2468: LFSR state loaded at reset.
- WARMUP, 8: number of 5-step LFSR advances after reset or reload before inputs are accepted; range 1..255.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous and active-low.
- seed_load  in  1  single-cycle pulse: reload the LFSR from seed_in and restart warm-up.
- seed_in  in  32  reseed value; 0 is replaced by 32'h0000_0001.
- in_valid  in  1  a/b/c valid.
- in_ready  out  1  stage can accept this cycle.
- a, b, c  in  1 each  unmasked operand bits.
- out_valid  out  1  share bundle valid.
- out_ready  in  1  downstream accepts the bundle.
- a0, a1, b0, b1, c0, c1  out  1 each  Boolean shares.
- rN0, rN1  out  1 each  fresh refresh randomness for the downstream gate.
- busy  out  1  high while in WARMUP.

## Operation
- LFSR: Fibonacci, polynomial x^32+x^22+x^2+x+1.
  - One step: fb = s[31]^s[21]^s[1]^s[0]; s_next = {s[30:0], fb}.
  - "Advance" means 5 unrolled steps within one cycle.
- Mask bits: m = s[4:0], taken from the state before the advance.
  - Shares: a0 = a^m[0], a1 = m[0]; b0 = b^m[1], b1 = m[1]; c0 = c^m[2], c1 = m[2].
  - Refresh bits: rN0 = m[3], rN1 = m[4].
- The LFSR advances exactly once per accepted input (in_valid & in_ready) and once per WARMUP cycle; otherwise it holds. No mask bit is ever reused.
- States:
  - WARMUP: advance every cycle while a 8-bit counter counts down from WARMUP−1; at counter 0 go to RUN. busy=1, in_ready=0.
  - RUN: in_ready = !out_valid | out_ready. Output register loads on accept.
- seed_load in any state:
  - LFSR ← (seed_in==0 ? 1 : seed_in); counter ← WARMUP−1; state ← WARMUP.
  - out_valid cleared and the held bundle discarded.
  - in_ready forced 0 that cycle, so no input is accepted.
- Reset: LFSR ← SEED (SEED==0 treated as 1); state WARMUP; counter WARMUP−1.

## Timing
- Reset values: in_ready=0, out_valid=0, busy=1, all share/rN outputs 0.
- First possible accept: cycle WARMUP after reset deassertion (cycles numbered from 0).
- Latency: accept at edge N → out_valid and bundle visible after edge N, through the cycle N+1 handshake.
- Full-throughput: with out_ready held 1, one accept per cycle; out_valid stays 1 and the bundle updates every cycle.
- Back-pressure: out_valid & !out_ready holds the bundle and LFSR stable; in_ready=0.
- Simultaneous pop and push (out_valid & out_ready & in_valid): the old bundle leaves and the new one loads on the same edge.
- Reset mid-operation: asynchronous clear to reset values; any in-flight bundle is lost.
- in_ready is combinational from state, out_valid and out_ready; there is no combinational path from in_valid.

## Structure
- Shared package masking_pkg holds:
  - LFSR_W, the tap positions and the default SEED;
  - the state enum {WARMUP, RUN};
  - function lfsr_adv5 (5-step unroll), reused by future mask sources.
- Sub-module masking_lfsr holds the state register, the load/advance controls and the zero-seed substitution. The top module contains the FSM, warm-up counter and output register.

## Test plan
- Reset, then hold in_valid=1 with a=1, b=1, c=0 → in_ready first rises at cycle 8. One cycle after accept: out_valid=1, a0^a1=1, b0^b1=1, c0^c1=0, busy=0.
- 64 back-to-back accepts with out_ready=1 and random a/b/c → one output per cycle. Every bundle recombines correctly, and m matches a golden lfsr_adv5 model seeded with 32'hACE1_2468 and pre-advanced 8 times.
- Hold out_ready=0 for 5 cycles with a bundle pending → in_ready=0, and the bundle and LFSR state are unchanged. Release → the same bundle pops and the next input is accepted on that edge.
- seed_load with seed_in=0 while out_valid=1 and in_valid=1 → input not accepted, out_valid=0, busy=1 for 8 cycles, LFSR internal state = 32'h1 on the next cycle.
- Assert rst_n=0 mid-stream for half a cycle → outputs clear immediately, and the post-reset mask sequence repeats the first-reset sequence exactly.
